// File: rtl/load_store_unit_pkg.sv
// Shared constants and FSM state type for the load/store unit and its data memory.
// Also used by benches that model the memory side of the LSU.
package constants;

    localparam int WORD_SIZE = 19;
    localparam int DM_DEPTH  = 1024;
    localparam int DM_ADDR_W = $clog2(DM_DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: sequences one CPU request into a single memory enable pulse and holds the response.
// Optional feature: define LSU_BOUNDS_CHECK_EN to fault requests with req_addr >= DM_DEPTH.
module load_store_unit #(
    parameter int WORD_SIZE = constants::WORD_SIZE,
    parameter int DM_DEPTH  = constants::DM_DEPTH,
    parameter int DM_ADDR_W = constants::DM_ADDR_W
) (
    input  logic                 clk,
    input  logic                 RESET_N,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 WR_EN_DM,
    output logic                 RD_EN_DM,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic [WORD_SIZE-1:0] dm_wdata,
    input  logic [WORD_SIZE-1:0] dm_rdata
);

    import constants::*;

    lsu_state_t state;
    logic       is_store;
    logic       addr_fault;

`ifdef LSU_BOUNDS_CHECK_EN
    assign addr_fault = (req_addr >= WORD_SIZE'(DM_DEPTH));
`else
    // Upper address bits are dropped so accesses wrap modulo DM_DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[WORD_SIZE-1:DM_ADDR_W];
    assign addr_fault     = 1'b0;
`endif

    // req_ready stays low while reset is held, even though state already reads IDLE.
    assign req_ready  = RESET_N && (state == IDLE);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            is_store   <= 1'b0;
            WR_EN_DM   <= 1'b0;
            RD_EN_DM   <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_store <= req_we;
                        if (addr_fault) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else begin
                            dm_addr  <= req_addr[DM_ADDR_W-1:0];
                            dm_wdata <= req_wdata;
                            WR_EN_DM <= req_we;
                            RD_EN_DM <= !req_we;
                            state    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    WR_EN_DM <= 1'b0;
                    RD_EN_DM <= 1'b0;
                    if (is_store) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Memory output register was loaded on the closing edge of ACCESS.
                    resp_rdata <= dm_rdata;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a behavioural memory and reference model.
module tb_load_store_unit;
    import constants::*;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 RESET_N = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic                 req_we = 1'b0;
    logic [WORD_SIZE-1:0] req_addr = '0;
    logic [WORD_SIZE-1:0] req_wdata = '0;
    logic                 resp_valid;
    logic                 resp_ready = 1'b0;
    logic [WORD_SIZE-1:0] resp_rdata;
    logic                 resp_err;
    logic                 WR_EN_DM;
    logic                 RD_EN_DM;
    logic [DM_ADDR_W-1:0] dm_addr;
    logic [WORD_SIZE-1:0] dm_wdata;
    logic [WORD_SIZE-1:0] dm_rdata = '0;

    load_store_unit dut (
        .clk(clk), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .WR_EN_DM(WR_EN_DM), .RD_EN_DM(RD_EN_DM),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Data memory with registered read port.
    bit [WORD_SIZE-1:0] mem [DM_DEPTH];
    always @(posedge clk) begin
        if (WR_EN_DM) mem[dm_addr] <= dm_wdata;
        if (RD_EN_DM) dm_rdata <= mem[dm_addr];
    end

    // Enable-pulse monitor, sampled where the memory samples.
    int                   wr_cnt = 0;
    int                   rd_cnt = 0;
    logic [DM_ADDR_W-1:0] last_addr = '0;
    logic [WORD_SIZE-1:0] last_wdata = '0;
    logic                 prev_wr = 1'b0;
    logic                 prev_rd = 1'b0;
    always @(posedge clk) begin
        if (WR_EN_DM === 1'b1) begin wr_cnt++; last_addr = dm_addr; last_wdata = dm_wdata; end
        if (RD_EN_DM === 1'b1) begin rd_cnt++; last_addr = dm_addr; end
        if (WR_EN_DM === 1'b1 || RD_EN_DM === 1'b1) begin
            check("en_exclusive", 32'(WR_EN_DM & RD_EN_DM), 0);
            check("en_single_cycle", 32'((WR_EN_DM & prev_wr) | (RD_EN_DM & prev_rd)), 0);
        end
        prev_wr = WR_EN_DM;
        prev_rd = RD_EN_DM;
    end

    // Reference: what each word of memory should hold from the CPU's point of view.
    bit [WORD_SIZE-1:0] ref_mem [DM_DEPTH];

    task automatic xact(input logic we, input logic [WORD_SIZE-1:0] addr,
                        input logic [WORD_SIZE-1:0] wd, input int hold);
        int                   lat, w0, r0, exp_lat;
        logic                 fault;
        logic [DM_ADDR_W-1:0] eff;
        logic [WORD_SIZE-1:0] exp_rd;
        fault  = BOUNDS && (addr >= WORD_SIZE'(DM_DEPTH));
        eff    = DM_ADDR_W'(addr % DM_DEPTH);
        exp_rd = '0;
        if (!fault) begin
            if (we) ref_mem[eff] = wd;
            else    exp_rd = ref_mem[eff];
        end
        exp_lat = fault ? 1 : (we ? 2 : 3);

        lat = 0;
        while (req_ready !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        check("req_ready_idle", 32'(req_ready), 1);
        w0 = wr_cnt; r0 = rd_cnt;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        resp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
        check("resp_latency", 32'(lat), 32'(exp_lat));
        check("wr_pulses", 32'(wr_cnt - w0), (we && !fault) ? 1 : 0);
        check("rd_pulses", 32'(rd_cnt - r0), (!we && !fault) ? 1 : 0);
        if (!fault) begin
            check("dm_addr", 32'(last_addr), 32'(eff));
            if (we) check("dm_wdata", 32'(last_wdata), 32'(wd));
        end
        check("resp_rdata", 32'(resp_rdata), 32'(exp_rd));
        check("resp_err", 32'(resp_err), 32'(fault));

        if (hold > 0) begin
            w0 = wr_cnt; r0 = rd_cnt;
            for (int i = 0; i < hold; i++) begin
                // A competing request while busy must be ignored.
                req_valid = 1'b1; req_we = ~we; req_addr = addr ^ 19'h1; req_wdata = ~wd;
                @(negedge clk);
                check("hold_valid", 32'(resp_valid), 1);
                check("hold_rdata", 32'(resp_rdata), 32'(exp_rd));
                check("hold_err", 32'(resp_err), 32'(fault));
                check("hold_req_ready", 32'(req_ready), 0);
            end
            req_valid = 1'b0;
            check("hold_no_access", 32'((wr_cnt - w0) + (rd_cnt - r0)), 0);
            resp_ready = 1'b1;
        end
        @(negedge clk);
        check("resp_drop", 32'(resp_valid), 0);
        check("req_ready_back", 32'(req_ready), 1);
        resp_ready = 1'b0;
    endtask

    initial begin
        int w0;
        logic                 we;
        logic [WORD_SIZE-1:0] addr;
        int                   r, hold;

        #12;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_wr_en", 32'(WR_EN_DM), 0);
        check("rst_rd_en", 32'(RD_EN_DM), 0);
        check("rst_rdata", 32'(resp_rdata), 0);
        check("rst_err", 32'(resp_err), 0);
        check("rst_dm_addr", 32'(dm_addr), 0);
        @(negedge clk);
        RESET_N = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 1);

        xact(1'b1, 19'h005, 19'h1ABCD, 0);
        xact(1'b0, 19'h005, 19'h0, 0);
        xact(1'b0, 19'h005, 19'h0, 5);
        xact(1'b1, 19'h00400, 19'h12345, 0);
        xact(1'b0, 19'h000, 19'h0, 0);
        xact(1'b0, 19'h7FFFF, 19'h0, 2);

        // Reset during the ACCESS cycle of a store: write is lost, no response.
        while (req_ready !== 1'b1) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 19'h000; req_wdata = 19'h55555;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_wr_high", 32'(WR_EN_DM), 1);
        w0 = wr_cnt;
        #1 RESET_N = 1'b0;
        #1;
        check("abort_wr_drop", 32'(WR_EN_DM), 0);
        check("abort_resp", 32'(resp_valid), 0);
        check("abort_ready_in_rst", 32'(req_ready), 0);
        #1 RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_resp", 32'(resp_valid), 0);
        end
        check("abort_no_write", 32'(wr_cnt - w0), 0);
        check("abort_idle", 32'(req_ready), 1);
        resp_ready = 1'b0;
        xact(1'b0, 19'h000, 19'h0, 0);

        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom % 2);
            r  = int'($urandom % 8);
            if (r == 0)      addr = WORD_SIZE'($urandom);
            else if (r == 1) addr = WORD_SIZE'($urandom_range(0, 15)) | 19'h00400;
            else             addr = WORD_SIZE'($urandom_range(0, 15));
            hold = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
            xact(we, addr, WORD_SIZE'($urandom), hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
